// File: rtl/toll_pkg.sv
// Shared types and helpers for the toll gate controller.
package toll_pkg;

  // FSM state encoding; the numeric values are visible on currentstate.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_PAY = 2'd1,
    ST_OPEN     = 2'd2,
    ST_ALARM    = 2'd3
  } state_e;

  // Fee for a vehicle class: base * (class + 1). Computed at 32 bits;
  // callers truncate to their own fee width.
  function automatic logic [31:0] fee_calc(input logic [1:0] cls,
                                           input logic [31:0] base);
    return base * (32'(cls) + 32'd1);
  endfunction

  // Saturating add against an explicit ceiling (widths up to 32 bits).
  // Incrementing a counter is sat_add(v, 1, max).
  function automatic logic [31:0] sat_add(input logic [31:0] v,
                                          input logic [31:0] a,
                                          input logic [31:0] maxv);
    logic [32:0] s;
    s = {1'b0, v} + {1'b0, a};
    return (s > {1'b0, maxv}) ? maxv : s[31:0];
  endfunction

  // All-ones value of a field of width w, zero-extended to 32 bits.
  function automatic logic [31:0] ones32(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/toll_gate_ctrl_timer.sv
// Payment timeout timer: counts cycles spent waiting for payment.
module toll_timer #(
  parameter int PAY_TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(PAY_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(PAY_TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  // Count up while enabled; park at the last value so it never wraps.
  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt_q <= '0;
    else if (en && !expire)
      cnt_q <= cnt_q + CW'(1);
  end

  assign expire = (cnt_q == LAST);

endmodule

// File: rtl/toll_gate_ctrl.sv
// Single-lane toll gate controller: vehicle detect, Hi-pass/cash payment
// with timeout, gate control, and saturating revenue/traffic statistics.
module toll_gate_ctrl
  import toll_pkg::*;
#(
  parameter int TAG_W       = 5,
  parameter int FEE_BASE    = 100,
  parameter int FEE_W       = 16,
  parameter int CNT_W       = 8,
  parameter int PAY_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             car,
  input  logic [TAG_W-1:0] hipass,
  input  logic             cash_ok,
  input  logic             end_output,
  output logic [1:0]       currentstate,
  output logic             gate_open,
  output logic             alarm,
  output logic [FEE_W-1:0] fee_due,
  output logic [FEE_W-1:0] fee_total,
  output logic [CNT_W-1:0] car_count,
  output logic [CNT_W-1:0] violation_count
);

  localparam logic [31:0] FEE_MAX = ones32(FEE_W);
  localparam logic [31:0] CNT_MAX = ones32(CNT_W);

  state_e           state_q;
  logic             gate_q, alarm_q;
  logic [FEE_W-1:0] fee_due_q, fee_tot_q;
  logic [CNT_W-1:0] car_q, viol_q;

  logic             pay_hp, pay, tmr_expire;
  logic [1:0]       cls;
  logic [FEE_W-1:0] fee_now, fee_c0;
  logic [FEE_W-1:0] tot_now_d, tot_c0_d;
  logic [CNT_W-1:0] car_d, viol_d;

  // Payment decode: a nonzero tag beats cash; cash is always class 0.
  assign pay_hp  = |hipass;
  assign pay     = pay_hp | cash_ok;
  assign cls     = pay_hp ? hipass[1:0] : 2'd0;
  assign fee_now = FEE_W'(fee_calc(cls, 32'(FEE_BASE)));
  assign fee_c0  = FEE_W'(fee_calc(2'd0, 32'(FEE_BASE)));

  // Next values of the saturating statistics.
  assign tot_now_d = FEE_W'(sat_add(32'(fee_tot_q), 32'(fee_now), FEE_MAX));
  assign tot_c0_d  = FEE_W'(sat_add(32'(fee_tot_q), 32'(fee_c0), FEE_MAX));
  assign car_d     = CNT_W'(sat_add(32'(car_q), 32'd1, CNT_MAX));
  assign viol_d    = CNT_W'(sat_add(32'(viol_q), 32'd1, CNT_MAX));

  // Timer is held clear in IDLE so it starts from 0 on entry to WAIT_PAY,
  // and only advances on unpaid waiting cycles.
  toll_timer #(.PAY_TIMEOUT(PAY_TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == ST_IDLE),
    .en     ((state_q == ST_WAIT_PAY) && !pay),
    .expire (tmr_expire)
  );

  // Gate FSM with registered outputs, fee latch and statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gate_q    <= 1'b0;
      alarm_q   <= 1'b0;
      fee_due_q <= '0;
      fee_tot_q <= '0;
      car_q     <= '0;
      viol_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (car) state_q <= ST_WAIT_PAY;
        end
        ST_WAIT_PAY: begin
          // Payment on the expiry edge still opens the gate.
          if (pay) begin
            state_q   <= ST_OPEN;
            gate_q    <= 1'b1;
            fee_due_q <= fee_now;
            fee_tot_q <= tot_now_d;
          end else if (tmr_expire) begin
            state_q <= ST_ALARM;
            alarm_q <= 1'b1;
          end
        end
        ST_OPEN: begin
          if (end_output) begin
            state_q <= ST_IDLE;
            gate_q  <= 1'b0;
            car_q   <= car_d;
          end
        end
        ST_ALARM: begin
          // Late cash beats a simultaneous exit; the car then exits as a payer.
          if (cash_ok) begin
            state_q   <= ST_OPEN;
            alarm_q   <= 1'b0;
            gate_q    <= 1'b1;
            fee_due_q <= fee_c0;
            fee_tot_q <= tot_c0_d;
          end else if (end_output) begin
            state_q <= ST_IDLE;
            alarm_q <= 1'b0;
            viol_q  <= viol_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gate_q  <= 1'b0;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign currentstate    = state_q;
  assign gate_open       = gate_q;
  assign alarm           = alarm_q;
  assign fee_due         = fee_due_q;
  assign fee_total       = fee_tot_q;
  assign car_count       = car_q;
  assign violation_count = viol_q;

endmodule

// File: tb/tb_toll_gate_ctrl.sv
// Directed self-checking bench for toll_gate_ctrl at default parameters.
module tb_toll_gate_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        car;
  logic [4:0]  hipass;
  logic        cash_ok;
  logic        end_output;
  logic [1:0]  currentstate;
  logic        gate_open;
  logic        alarm;
  logic [15:0] fee_due;
  logic [15:0] fee_total;
  logic [7:0]  car_count;
  logic [7:0]  violation_count;

  int n_cmp = 0;
  int n_err = 0;

  toll_gate_ctrl #(
    .TAG_W(5), .FEE_BASE(100), .FEE_W(16), .CNT_W(8), .PAY_TIMEOUT(8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .car             (car),
    .hipass          (hipass),
    .cash_ok         (cash_ok),
    .end_output      (end_output),
    .currentstate    (currentstate),
    .gate_open       (gate_open),
    .alarm           (alarm),
    .fee_due         (fee_due),
    .fee_total       (fee_total),
    .car_count       (car_count),
    .violation_count (violation_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_in();
    car = 0; hipass = '0; cash_ok = 0; end_output = 0;
  endtask

  // Full class-3 Hi-pass vehicle: IDLE -> WAIT_PAY -> OPEN -> IDLE.
  task automatic hp3_car();
    car = 1; step(); car = 0;
    hipass = 5'b00011; step(); hipass = '0;
    end_output = 1; step(); end_output = 0;
  endtask

  initial begin
    rst = 1;
    idle_in();
    // Reset with random inputs.
    for (int i = 0; i < 2; i++) begin
      car = 1'($urandom); hipass = 5'($urandom); cash_ok = 1'($urandom);
      end_output = 1'($urandom);
      step();
    end
    chk("rst_state", currentstate, 0);
    chk("rst_gate", gate_open, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_fee_due", fee_due, 0);
    chk("rst_fee_total", fee_total, 0);
    chk("rst_cars", car_count, 0);
    chk("rst_viol", violation_count, 0);
    rst = 0; idle_in(); step();
    chk("idle_hold", currentstate, 0);

    // Hi-pass class 3.
    car = 1; step(); car = 0;
    chk("hp_wait", currentstate, 1);
    hipass = 5'b01111; step(); hipass = '0;
    chk("hp_open", currentstate, 2);
    chk("hp_gate", gate_open, 1);
    chk("hp_fee", fee_due, 400);
    chk("hp_total", fee_total, 400);
    end_output = 1; step(); end_output = 0;
    chk("hp_exit", currentstate, 0);
    chk("hp_gate_cl", gate_open, 0);
    chk("hp_cars", car_count, 1);

    // Cash.
    car = 1; step(); car = 0;
    cash_ok = 1; step(); cash_ok = 0;
    chk("cash_fee", fee_due, 100);
    chk("cash_total", fee_total, 500);
    end_output = 1; step(); end_output = 0;
    chk("cash_cars", car_count, 2);

    // Timeout: still waiting after 7 unpaid edges, alarm on the 8th.
    car = 1; step(); car = 0;
    step(7);
    chk("to_wait7", currentstate, 1);
    chk("to_noalarm", alarm, 0);
    step();
    chk("to_alarm_st", currentstate, 3);
    chk("to_alarm", alarm, 1);
    hipass = 5'b00011; step(); hipass = '0;
    chk("alarm_ign_hp", currentstate, 3);
    end_output = 1; step(); end_output = 0;
    chk("to_exit", currentstate, 0);
    chk("to_alarm_cl", alarm, 0);
    chk("to_viol", violation_count, 1);
    chk("to_cars", car_count, 2);
    chk("to_total", fee_total, 500);

    // Payment on the exact timeout edge wins.
    car = 1; step(); car = 0;
    step(7);
    hipass = 5'b00001; step(); hipass = '0;
    chk("edge_state", currentstate, 2);
    chk("edge_alarm", alarm, 0);
    chk("edge_fee", fee_due, 200);
    chk("edge_total", fee_total, 700);
    end_output = 1; step(); end_output = 0;
    chk("edge_cars", car_count, 3);

    // Hi-pass and cash together: class 2 tag fee charged.
    car = 1; step(); car = 0;
    hipass = 5'b00010; cash_ok = 1; step(); hipass = '0; cash_ok = 0;
    chk("both_fee", fee_due, 300);
    chk("both_total", fee_total, 1000);
    end_output = 1; step(); end_output = 0;
    chk("both_cars", car_count, 4);

    // Late cash in ALARM together with exit: cash wins, counted as payer.
    car = 1; step(); car = 0;
    step(8);
    chk("late_alarm", currentstate, 3);
    cash_ok = 1; end_output = 1; step(); cash_ok = 0; end_output = 0;
    chk("late_state", currentstate, 2);
    chk("late_gate", gate_open, 1);
    chk("late_fee", fee_due, 100);
    chk("late_total", fee_total, 1100);
    chk("late_viol", violation_count, 1);
    end_output = 1; step(); end_output = 0;
    chk("late_cars", car_count, 5);
    chk("late_viol2", violation_count, 1);

    // Exit sensor ignored while waiting for payment.
    car = 1; step(); car = 0;
    end_output = 1; step(); end_output = 0;
    chk("wait_ign_end", currentstate, 1);
    hipass = 5'b00011; step(); hipass = '0;
    chk("wait_total", fee_total, 1500);
    end_output = 1; step(); end_output = 0;
    chk("wait_cars", car_count, 6);

    // Revenue saturation: 160 x 400 -> 65500, then two more clip at FFFF.
    for (int i = 0; i < 160; i++) hp3_car();
    chk("sat_pre", fee_total, 65500);
    chk("sat_cars", car_count, 166);
    hp3_car();
    chk("sat_hit", fee_total, 16'hFFFF);
    hp3_car();
    chk("sat_hold", fee_total, 16'hFFFF);
    chk("sat_cars2", car_count, 168);

    // Reset while OPEN.
    car = 1; step(); car = 0;
    cash_ok = 1; step(); cash_ok = 0;
    chk("mid_open", currentstate, 2);
    rst = 1; car = 1; step(); rst = 0; car = 0;
    chk("mid_state", currentstate, 0);
    chk("mid_gate", gate_open, 0);
    chk("mid_total", fee_total, 0);
    chk("mid_fee", fee_due, 0);
    chk("mid_cars", car_count, 0);
    chk("mid_viol", violation_count, 0);

    // car held high through a full cycle re-enters WAIT_PAY after IDLE.
    car = 1; step();
    cash_ok = 1; step(); cash_ok = 0;
    end_output = 1; step(); end_output = 0;
    chk("held_idle", currentstate, 0);
    chk("held_cars", car_count, 1);
    step();
    chk("held_rewait", currentstate, 1);
    idle_in();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
